trsq_fetch_ctrl: RTL

- Instruction-fetch sequencer for the TRSQ8 core. Owns the program counter and drives the address of the combinational program ROM (13-bit address, 15-bit instruction word).
- Registers each fetched word into a one-entry fetch stage with a valid bit.
- Handles stall, jump, call and return redirects. Holds a hardware return-address stack.
- Sits between `prom` and the decode/execute stage.

---
 rtl/trsq_pkg.sv | 24 ++
 rtl/trsq_fetch_ctrl_if.sv | 50 +++++
 rtl/trsq_call_stack.sv | 58 +++++
 rtl/trsq_fetch_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/trsq_pkg.sv
// Shared definitions for the TRSQ8 instruction-fetch slice.
//   PC_W / INST_W : program counter and instruction widths
//   NOP           : all-zero instruction word, loaded into the fetch stage on reset
//   fetch_state_e : fetch sequencer states
//   pc_inc        : wrapping program-counter increment
package trsq_pkg;

    localparam int unsigned PC_W   = 13;
    localparam int unsigned INST_W = 15;

    localparam logic [INST_W-1:0] NOP = '0;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_REFILL
    } fetch_state_e;

    // Modulo 2^PC_W: 8191 rolls over to 0.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/trsq_fetch_ctrl_if.sv
// Bundle of the fetch sequencer's control, ROM and fetch-stage signals.
//   master : fetch controller view (drives the ROM address and the fetch stage)
//   slave  : core/ROM view (drives stall, redirects, target and ROM data)
interface trsq_fetch_ctrl_if;
    import trsq_pkg::*;

    logic              STALL_ip;
    logic              JUMP_ip;
    logic              CALL_ip;
    logic              RET_ip;
    logic [PC_W-1:0]   TARGET_ip;
    logic [PC_W-1:0]   PROM_ADDR_op;
    logic [INST_W-1:0] PROM_DATA_ip;
    logic [INST_W-1:0] INST_op;
    logic [PC_W-1:0]   PC_op;
    logic              INST_VALID_op;
    logic              STACK_OVF_op;
    logic              STACK_UNF_op;

    modport master (
        input  STALL_ip,
        input  JUMP_ip,
        input  CALL_ip,
        input  RET_ip,
        input  TARGET_ip,
        input  PROM_DATA_ip,
        output PROM_ADDR_op,
        output INST_op,
        output PC_op,
        output INST_VALID_op,
        output STACK_OVF_op,
        output STACK_UNF_op
    );

    modport slave (
        output STALL_ip,
        output JUMP_ip,
        output CALL_ip,
        output RET_ip,
        output TARGET_ip,
        output PROM_DATA_ip,
        input  PROM_ADDR_op,
        input  INST_op,
        input  PC_op,
        input  INST_VALID_op,
        input  STACK_OVF_op,
        input  STACK_UNF_op
    );

endinterface

// File: rtl/trsq_call_stack.sv
// Hardware return-address stack (LIFO).
//   clk, rst : clock and synchronous active-high reset (empties the stack)
//   push     : write wdata on top; ignored while full
//   pop      : drop the top entry; ignored while empty
//   wdata    : return address to push
//   rdata    : current top of stack (meaningless while empty)
//   full     : STACK_DEPTH entries held
//   empty    : no entries held
// The caller never asserts push and pop in the same cycle.
module trsq_call_stack
    import trsq_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] wdata,
    output logic [PC_W-1:0] rdata,
    output logic            full,
    output logic            empty
);

    localparam int unsigned AW = $clog2(STACK_DEPTH);
    localparam int unsigned SW = AW + 1;

    logic [PC_W-1:0] mem_q [STACK_DEPTH];
    logic [SW-1:0]   sp_q;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    assign wr_idx = sp_q[AW-1:0];
    // Wraps to the last slot when full, which is the top entry in that case.
    assign rd_idx = wr_idx - 1'b1;

    assign full  = (sp_q == SW'(STACK_DEPTH));
    assign empty = (sp_q == '0);
    assign rdata = mem_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + 1'b1;
        end else if (pop && !empty) begin
            sp_q <= sp_q - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read below the stack pointer.
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/trsq_fetch_ctrl.sv
// TRSQ8 instruction-fetch sequencer.
//   CLK_ip : clock, all state updates on the rising edge
//   RST_ip : synchronous active-high reset, overrides every other input
//   bus    : trsq_fetch_ctrl_if.master
//            STALL_ip/JUMP_ip/CALL_ip/RET_ip/TARGET_ip  control from decode/execute
//            PROM_ADDR_op/PROM_DATA_ip                  combinational program ROM port
//            INST_op/PC_op/INST_VALID_op                one-entry fetch stage
//            STACK_OVF_op/STACK_UNF_op                  sticky return-stack error flags
// Redirects act on the live instruction in the fetch stage, squash it and insert one bubble
// while the new target is fetched. Priority is RET > CALL > JUMP.
module trsq_fetch_ctrl
    import trsq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter int unsigned     STACK_DEPTH  = 8
) (
    input  logic                CLK_ip,
    input  logic                RST_ip,
    trsq_fetch_ctrl_if.master   bus
);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]   pc_out_q, pc_out_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              take_ret;
    logic              take_call;
    logic              take_jump;
    logic              redirect;

    logic              stk_push;
    logic              stk_pop;
    logic [PC_W-1:0]   stk_rdata;
    logic              stk_full;
    logic              stk_empty;

    trsq_call_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_call_stack (
        .clk   (CLK_ip),
        .rst   (RST_ip),
        .push  (stk_push),
        .pop   (stk_pop),
        .wdata (pc_inc(pc_out_q)),
        .rdata (stk_rdata),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Redirects need a live instruction to act on and an unstalled pipe.
    assign take_ret  = !bus.STALL_ip && valid_q && bus.RET_ip;
    assign take_call = !bus.STALL_ip && valid_q && bus.CALL_ip && !bus.RET_ip;
    assign take_jump = !bus.STALL_ip && valid_q && bus.JUMP_ip && !bus.CALL_ip
                       && !bus.RET_ip;
    assign redirect  = take_ret || take_call || take_jump;

    // The stack ignores a push while full and a pop while empty on its own.
    assign stk_push  = take_call;
    assign stk_pop   = take_ret;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (!bus.STALL_ip) begin
            if (redirect) begin
                if (take_ret) begin
                    if (stk_empty) begin
                        pc_d  = RESET_VECTOR;
                        unf_d = 1'b1;
                    end else begin
                        pc_d  = stk_rdata;
                    end
                end else begin
                    pc_d = bus.TARGET_ip;
                    if (take_call && stk_full) begin
                        ovf_d = 1'b1;
                    end
                end
                valid_d = 1'b0;
                state_d = S_REFILL;
            end else begin
                unique case (state_q)
                    // Lets the ROM address settle after reset; the first word is
                    // captured on the following edge.
                    S_BOOT: begin
                        state_d = S_RUN;
                    end
                    S_RUN, S_REFILL: begin
                        inst_d   = bus.PROM_DATA_ip;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_inc(pc_q);
                        state_d  = S_RUN;
                    end
                    default: begin
                        state_d = S_BOOT;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK_ip) begin
        if (RST_ip) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_VECTOR;
            inst_q   <= NOP;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.PROM_ADDR_op  = pc_q;
    assign bus.INST_op       = inst_q;
    assign bus.PC_op         = pc_out_q;
    assign bus.INST_VALID_op = valid_q;
    assign bus.STACK_OVF_op  = ovf_q;
    assign bus.STACK_UNF_op  = unf_q;

endmodule
